// File: rtl/spart_if.sv
// Processor-side bus control and status strobes for the spart serial port.
// The shared data lines stay a plain inout on the spart port list.
interface spart_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;

  modport master (output iocs, output iorw, output ioaddr, input rda, input tbr);
  modport slave  (input iocs, input iorw, input ioaddr, output rda, output tbr);
endinterface

// File: rtl/spart.sv
// Programmable-baud 8N1 UART with an 8-bit bidirectional register bus.
// Baud tick = DB+1 clocks, 16 ticks per bit; RX samples mid-bit after a 2-flop sync.
module spart (
  input  logic       clk,
  input  logic       rst,
  spart_if.slave     bus,
  inout  wire  [7:0] databus,
  output logic       txd,
  input  logic       rxd
);
  localparam int unsigned DB_W   = 16;
  localparam int unsigned TCNT_W = 4;
  localparam int unsigned BIT_W  = 4;
  localparam logic [DB_W-1:0] DB_RST = 16'd324;

  typedef enum logic [1:0] {TX_IDLE, TX_WAIT, TX_SHIFT} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  logic [DB_W-1:0]   db_q, db_d, cnt_q;
  logic              wr_c, rd_c, db_wr_c, tick_c;
  logic [7:0]        rdata_c;

  tx_state_e         tx_state_q;
  logic [8:0]        tx_sh_q;
  logic [BIT_W-1:0]  tx_bit_q;
  logic [TCNT_W-1:0] tx_tcnt_q;
  logic              txd_q, tbr_q;

  rx_state_e         rx_state_q;
  logic              rx_s1_q, rx_s2_q, rx_s3_q;
  logic [7:0]        rx_sh_q, rx_buf_q;
  logic [BIT_W-1:0]  rx_bit_q;
  logic [TCNT_W-1:0] rx_tcnt_q;
  logic              rda_q;

  assign wr_c    = bus.iocs & ~bus.iorw;
  assign rd_c    = bus.iocs &  bus.iorw;
  assign db_wr_c = wr_c & bus.ioaddr[1];
  assign tick_c  = (cnt_q == '0);

  always_comb begin
    db_d = db_q;
    if (db_wr_c && !bus.ioaddr[0]) db_d[7:0]  = databus;
    if (db_wr_c &&  bus.ioaddr[0]) db_d[15:8] = databus;
  end

  always_comb begin
    rdata_c = '0;
    case (bus.ioaddr)
      2'b00: rdata_c = rx_buf_q;
      2'b01: rdata_c = {6'b0, rda_q, tbr_q};
      2'b10: rdata_c = db_q[7:0];
      2'b11: rdata_c = db_q[15:8];
      default: rdata_c = '0;
    endcase
  end

  assign databus = rd_c ? rdata_c : 8'bz;
  assign txd     = txd_q;
  assign bus.tbr = tbr_q;
  assign bus.rda = rda_q;

  // Divisor register and baud down-counter; a divisor write restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_q  <= DB_RST;
      cnt_q <= DB_RST;
    end else begin
      db_q <= db_d;
      if (db_wr_c)     cnt_q <= db_d;
      else if (tick_c) cnt_q <= db_q;
      else             cnt_q <= cnt_q - 16'd1;
    end
  end

  // Transmitter: start bit begins on the first tick after the load.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_sh_q    <= '1;
      tx_bit_q   <= '0;
      tx_tcnt_q  <= '0;
      txd_q      <= 1'b1;
      tbr_q      <= 1'b1;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if (wr_c && bus.ioaddr == 2'b00) begin
            tx_sh_q    <= {1'b1, databus};
            tbr_q      <= 1'b0;
            tx_state_q <= TX_WAIT;
          end
        end
        TX_WAIT: begin
          if (tick_c) begin
            txd_q      <= 1'b0;
            tx_tcnt_q  <= '0;
            tx_bit_q   <= '0;
            tx_state_q <= TX_SHIFT;
          end
        end
        TX_SHIFT: begin
          if (tick_c) begin
            if (tx_tcnt_q == 4'd15) begin
              tx_tcnt_q <= '0;
              if (tx_bit_q == 4'd9) begin
                txd_q      <= 1'b1;
                tbr_q      <= 1'b1;
                tx_state_q <= TX_IDLE;
              end else begin
                tx_bit_q <= tx_bit_q + 4'd1;
                txd_q    <= tx_sh_q[0];
                tx_sh_q  <= {1'b1, tx_sh_q[8:1]};
              end
            end else begin
              tx_tcnt_q <= tx_tcnt_q + 4'd1;
            end
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  // Receiver; a completing byte overrides a same-cycle read clearing rda.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_sh_q    <= '0;
      rx_buf_q   <= '0;
      rx_bit_q   <= '0;
      rx_tcnt_q  <= '0;
      rda_q      <= 1'b0;
    end else begin
      rx_s1_q <= rxd;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
      if (rd_c && bus.ioaddr == 2'b00) rda_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_s3_q && !rx_s2_q) begin
            rx_tcnt_q  <= '0;
            rx_state_q <= RX_START;
          end
        end
        RX_START: begin
          if (tick_c) begin
            if (rx_tcnt_q == 4'd7) begin
              rx_tcnt_q  <= '0;
              rx_bit_q   <= '0;
              rx_state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
            end else begin
              rx_tcnt_q <= rx_tcnt_q + 4'd1;
            end
          end
        end
        RX_DATA: begin
          if (tick_c) begin
            if (rx_tcnt_q == 4'd15) begin
              rx_tcnt_q <= '0;
              rx_sh_q   <= {rx_s2_q, rx_sh_q[7:1]};
              if (rx_bit_q == 4'd7) rx_state_q <= RX_STOP;
              else                  rx_bit_q   <= rx_bit_q + 4'd1;
            end else begin
              rx_tcnt_q <= rx_tcnt_q + 4'd1;
            end
          end
        end
        RX_STOP: begin
          if (tick_c) begin
            if (rx_tcnt_q == 4'd15) begin
              rx_tcnt_q  <= '0;
              rx_state_q <= RX_IDLE;
              if (rx_s2_q) begin
                rx_buf_q <= rx_sh_q;
                rda_q    <= 1'b1;
              end
            end else begin
              rx_tcnt_q <= rx_tcnt_q + 4'd1;
            end
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spart.sv
// Randomized bench for spart: expected serial waveforms, received bytes and
// status come from a frame-level model of the port kept in this file.
module tb_spart;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spart_if bus ();
  wire  [7:0] databus;
  wire        txd;
  wire        rxd;
  logic [7:0] tb_data;
  logic       tb_drive;
  logic       loop_en;
  logic       rx_drv;

  assign databus = tb_drive ? tb_data : 8'bz;
  assign rxd     = loop_en ? txd : rx_drv;

  spart dut (.clk(clk), .rst(rst), .bus(bus), .databus(databus), .txd(txd), .rxd(rxd));

  int         n_checks;
  int         n_errors;
  int         db_m;
  logic       exp_rda;
  logic [7:0] exp_buf;
  logic [7:0] rd;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int bit_clks();
    return 16 * (db_m + 1);
  endfunction

  task automatic bus_idle();
    bus.iocs   = 1'b0;
    bus.iorw   = 1'b1;
    bus.ioaddr = 2'b00;
    tb_drive   = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [7:0] data);
    @(negedge clk);
    bus.iocs = 1'b1; bus.iorw = 1'b0; bus.ioaddr = addr;
    tb_data = data; tb_drive = 1'b1;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [7:0] data);
    @(negedge clk);
    bus.iocs = 1'b1; bus.iorw = 1'b1; bus.ioaddr = addr; tb_drive = 1'b0;
    #1 data = databus;
    @(negedge clk);
    bus_idle();
    if (addr == 2'b00) exp_rda = 1'b0;
  endtask

  task automatic program_db(input int db);
    bus_write(2'b10, 8'(db));
    bus_write(2'b11, 8'(db >> 8));
    db_m = db;
  endtask

  // Expects the frame {0, d[0..7], 1}; optionally attempts a write mid-frame.
  task automatic tx_frame_check(input string tag, input logic [7:0] d, input bit intrude);
    int n;
    int bp;
    logic [9:0] frame;
    frame = {1'b1, d, 1'b0};
    bp = bit_clks();
    n = 0;
    while (txd !== 1'b0 && n < 2 * (db_m + 1) + 10) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_start"}, 8'(txd), 8'h00);
    if (txd !== 1'b0) return;
    repeat (bp / 2) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      check_eq($sformatf("%s_b%0d", tag, k), 8'(txd), 8'(frame[k]));
      if (k == 3 && intrude) begin
        bus.iocs = 1'b1; bus.iorw = 1'b0; bus.ioaddr = 2'b00;
        tb_data = ~d; tb_drive = 1'b1;
        @(negedge clk);
        bus_idle();
        repeat (bp - 1) @(negedge clk);
      end else if (k < 9) begin
        repeat (bp) @(negedge clk);
      end
    end
    check_eq({tag, "_busy"}, 8'(bus.tbr), 8'h00);
    repeat (bp / 2 + 2) @(negedge clk);
    check_eq({tag, "_tbr"}, 8'(bus.tbr), 8'h01);
  endtask

  task automatic serial_send(input logic [7:0] d, input logic stop_v);
    int bp;
    bp = bit_clks();
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (bp) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      repeat (bp) @(negedge clk);
    end
    rx_drv = stop_v;
    repeat (bp) @(negedge clk);
    rx_drv = 1'b1;
    repeat (bp / 2) @(negedge clk);
    if (stop_v) begin
      exp_rda = 1'b1;
      exp_buf = d;
    end
  endtask

  task automatic check_rx(input string tag);
    check_eq({tag, "_rda"}, 8'(bus.rda), 8'(exp_rda));
    bus_read(2'b00, rd);
    check_eq({tag, "_data"}, rd, exp_buf);
    check_eq({tag, "_clr"}, 8'(bus.rda), 8'(exp_rda));
  endtask

  initial begin
    #(10 * 100000);
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    logic [7:0] b2;
    n_checks = 0; n_errors = 0;
    bus_idle();
    tb_data = '0; loop_en = 1'b0; rx_drv = 1'b1;
    exp_rda = 1'b0; exp_buf = '0; db_m = 324;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_txd", 8'(txd), 8'h01);
    check_eq("rst_tbr", 8'(bus.tbr), 8'h01);
    check_eq("rst_rda", 8'(bus.rda), 8'h00);
    rst = 1'b0;
    bus_read(2'b01, rd); check_eq("rst_status", rd, 8'h01);
    bus_read(2'b10, rd); check_eq("rst_db_lo", rd, 8'(db_m));
    bus_read(2'b11, rd); check_eq("rst_db_hi", rd, 8'(db_m >> 8));
    bus_read(2'b00, rd); check_eq("rst_rxbuf", rd, 8'h00);

    program_db(4);
    bus_read(2'b10, rd); check_eq("db_lo", rd, 8'h04);
    bus_read(2'b11, rd); check_eq("db_hi", rd, 8'h00);

    // Held two-cycle write must send exactly one frame.
    @(negedge clk);
    bus.iocs = 1'b1; bus.iorw = 1'b0; bus.ioaddr = 2'b00; tb_data = 8'h6D; tb_drive = 1'b1;
    @(negedge clk);
    check_eq("tbr_after_load", 8'(bus.tbr), 8'h00);
    @(negedge clk);
    bus_idle();
    tx_frame_check("tx6d", 8'h6D, 1'b0);
    for (int i = 0; i < 4; i++) begin
      repeat (bit_clks() / 2) @(negedge clk);
      check_eq("one_frame_txd", 8'(txd), 8'h01);
    end
    check_eq("one_frame_tbr", 8'(bus.tbr), 8'h01);

    bus_write(2'b00, 8'h3C);
    tx_frame_check("txbusy", 8'h3C, 1'b1);

    loop_en = 1'b1;
    bus_write(2'b00, 8'hA5);
    tx_frame_check("lb_a5", 8'hA5, 1'b0);
    exp_rda = 1'b1; exp_buf = 8'hA5;
    check_rx("lb_a5");
    bus_read(2'b01, rd); check_eq("lb_status", rd, {6'b0, exp_rda, 1'b1});

    for (int i = 0; i < 4; i++) begin
      program_db(int'($urandom_range(1, 5)));
      b = 8'($urandom);
      bus_write(2'b00, b);
      tx_frame_check($sformatf("lbr%0d", i), b, 1'b0);
      exp_rda = 1'b1; exp_buf = b;
      check_rx($sformatf("lbr%0d", i));
    end
    loop_en = 1'b0;

    program_db(4);
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      serial_send(b, 1'b1);
      check_rx($sformatf("rx%0d", i));
    end

    @(negedge clk);
    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    repeat (3 * bit_clks()) @(negedge clk);
    check_eq("glitch_rda", 8'(bus.rda), 8'h00);

    serial_send(8'h5A, 1'b0);
    repeat (bit_clks()) @(negedge clk);
    check_eq("frame_err_rda", 8'(bus.rda), 8'h00);
    bus_read(2'b01, rd); check_eq("frame_err_status", rd, 8'h01);

    b = 8'($urandom);
    b2 = ~b;
    serial_send(b, 1'b1);
    serial_send(b2, 1'b1);
    check_rx("overrun");

    // Reset in the middle of a transmit with a byte pending.
    serial_send(8'hC3, 1'b1);
    bus_write(2'b00, 8'h81);
    repeat (3 * bit_clks()) @(negedge clk);
    check_eq("pre_rst_tbr", 8'(bus.tbr), 8'h00);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_txd", 8'(txd), 8'h01);
    check_eq("midrst_tbr", 8'(bus.tbr), 8'h01);
    check_eq("midrst_rda", 8'(bus.rda), 8'h00);
    rst = 1'b0;
    exp_rda = 1'b0; exp_buf = 8'h00; db_m = 324;
    bus_read(2'b10, rd); check_eq("midrst_db_lo", rd, 8'(db_m));
    bus_read(2'b00, rd); check_eq("midrst_rxbuf", rd, exp_buf);
    bus_read(2'b01, rd); check_eq("midrst_status", rd, 8'h01);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
